// File: rtl/branch_predict_unit_pkg.sv
// Shared constants and counter encodings for the branch predictor.
package branch_predict_unit_pkg;

  localparam int PC_W      = 8;
  localparam int IDX_W_DEF = 4;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_e;

endpackage

// File: rtl/branch_predict_unit_sat_counter2.sv
// Next-state logic for one 2-bit saturating predictor counter, including the
// reload applied when the entry belongs to a different branch.
module sat_counter2
  import branch_predict_unit_pkg::*;
(
  input  logic [1:0] cnt_i,
  input  logic       hit_i,
  input  logic       taken_i,
  output logic [1:0] cnt_o
);

  always_comb begin
    cnt_o = cnt_i;
    if (!hit_i) begin
      // A new branch starts weakly biased toward its first observed outcome.
      cnt_o = taken_i ? CTR_WT : CTR_WNT;
    end else if (taken_i) begin
      if (cnt_i != CTR_ST) cnt_o = cnt_i + 2'd1;
    end else begin
      if (cnt_i != CTR_SNT) cnt_o = cnt_i - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Direct-mapped branch predictor: combinational fetch lookup, EX-stage
// resolution with misprediction redirect, and saturating statistics.
module branch_predict_unit
  import branch_predict_unit_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [PC_W-1:0] pcF,
  output logic            predictionF,
  output logic [PC_W-1:0] predTargetF,
  input  logic            Branch_EX,
  input  logic            bit26_EX,
  input  logic            zero_EX,
  input  logic            kill_EX,
  input  logic [PC_W-1:0] pc_EX,
  input  logic [PC_W-1:0] pcBranch_EX,
  input  logic [PC_W-1:0] pcPlus2_EX,
  input  logic            prediction_EX,
  output logic            mispredict_EX,
  output logic [PC_W-1:0] redirectPC_EX,
  output logic [15:0]     mispredCount,
  output logic [15:0]     branchCount
);

  localparam int NUM   = 1 << IDX_W;
  localparam int TAG_W = PC_W - IDX_W;

  logic             valid_q [NUM];
  logic             valid_d [NUM];
  logic [1:0]       cnt_q   [NUM];
  logic [1:0]       cnt_d   [NUM];
  logic [TAG_W-1:0] tag_q   [NUM];
  logic [TAG_W-1:0] tag_d   [NUM];
  logic [PC_W-1:0]  tgt_q   [NUM];
  logic [PC_W-1:0]  tgt_d   [NUM];

  logic [15:0] mispred_cnt_q, mispred_cnt_d;
  logic [15:0] branch_cnt_q, branch_cnt_d;

  logic [IDX_W-1:0] idx_f, idx_ex;
  logic [TAG_W-1:0] tag_f, tag_ex;
  logic             hit_f, hit_ex;
  logic             taken, active;
  logic [1:0]       cnt_upd;

  // Fetch lookup reads only registered state, so a same-cycle update is not bypassed.
  assign idx_f       = pcF[IDX_W-1:0];
  assign tag_f       = pcF[PC_W-1:IDX_W];
  assign hit_f       = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
  assign predictionF = hit_f && (cnt_q[idx_f] >= CTR_WT);
  assign predTargetF = predictionF ? tgt_q[idx_f] : '0;

  assign taken         = Branch_EX & (bit26_EX ? ~zero_EX : zero_EX);
  assign active        = Branch_EX & ~kill_EX;
  assign mispredict_EX = active & (taken != prediction_EX);
  assign redirectPC_EX = mispredict_EX ? (taken ? pcBranch_EX : pcPlus2_EX) : '0;

  assign idx_ex = pc_EX[IDX_W-1:0];
  assign tag_ex = pc_EX[PC_W-1:IDX_W];
  assign hit_ex = valid_q[idx_ex] && (tag_q[idx_ex] == tag_ex);

  sat_counter2 u_sat_counter2 (
    .cnt_i   (cnt_q[idx_ex]),
    .hit_i   (hit_ex),
    .taken_i (taken),
    .cnt_o   (cnt_upd)
  );

  always_comb begin
    valid_d = valid_q;
    cnt_d   = cnt_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    if (active) begin
      valid_d[idx_ex] = 1'b1;
      tag_d[idx_ex]   = tag_ex;
      cnt_d[idx_ex]   = cnt_upd;
      if (taken) tgt_d[idx_ex] = pcBranch_EX;
    end
  end

  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (active && (branch_cnt_q != 16'hFFFF)) branch_cnt_d = branch_cnt_q + 16'd1;
    if (mispredict_EX && (mispred_cnt_q != 16'hFFFF)) mispred_cnt_d = mispred_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM; i++) begin
        valid_q[i] <= 1'b0;
        cnt_q[i]   <= CTR_WNT;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
      end
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      valid_q       <= valid_d;
      cnt_q         <= cnt_d;
      tag_q         <= tag_d;
      tgt_q         <= tgt_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign mispredCount = mispred_cnt_q;
  assign branchCount  = branch_cnt_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed vector bench for branch_predict_unit.
module tb_branch_predict_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  pcF;
  logic        predictionF;
  logic [7:0]  predTargetF;
  logic        Branch_EX, bit26_EX, zero_EX, kill_EX, prediction_EX;
  logic [7:0]  pc_EX, pcBranch_EX, pcPlus2_EX;
  logic        mispredict_EX;
  logic [7:0]  redirectPC_EX;
  logic [15:0] mispredCount, branchCount;

  int n_checks = 0;
  int n_errors = 0;

  branch_predict_unit #(.IDX_W(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .pcF           (pcF),
    .predictionF   (predictionF),
    .predTargetF   (predTargetF),
    .Branch_EX     (Branch_EX),
    .bit26_EX      (bit26_EX),
    .zero_EX       (zero_EX),
    .kill_EX       (kill_EX),
    .pc_EX         (pc_EX),
    .pcBranch_EX   (pcBranch_EX),
    .pcPlus2_EX    (pcPlus2_EX),
    .prediction_EX (prediction_EX),
    .mispredict_EX (mispredict_EX),
    .redirectPC_EX (redirectPC_EX),
    .mispredCount  (mispredCount),
    .branchCount   (branchCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  pcf;
    logic        br, b26, zero, kill;
    logic [7:0]  pcex, pcb, pcp2;
    logic        pex;
    logic        epred;
    logic [7:0]  etgt;
    logic        emis;
    logic [7:0]  ered;
    logic [15:0] emc, ebc;
  } vec_t;

  vec_t vecs [20];

  function automatic vec_t mk(input logic [7:0] pcf, input logic br, input logic b26,
                              input logic zero, input logic kill, input logic [7:0] pcex,
                              input logic [7:0] pcb, input logic [7:0] pcp2, input logic pex,
                              input logic epred, input logic [7:0] etgt, input logic emis,
                              input logic [7:0] ered, input logic [15:0] emc,
                              input logic [15:0] ebc);
    vec_t v;
    v.pcf = pcf; v.br = br; v.b26 = b26; v.zero = zero; v.kill = kill;
    v.pcex = pcex; v.pcb = pcb; v.pcp2 = pcp2; v.pex = pex;
    v.epred = epred; v.etgt = etgt; v.emis = emis; v.ered = ered;
    v.emc = emc; v.ebc = ebc;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive_idle(input logic [7:0] pcf);
    pcF = pcf; Branch_EX = 1'b0; bit26_EX = 1'b0; zero_EX = 1'b0; kill_EX = 1'b0;
    pc_EX = 8'h00; pcBranch_EX = 8'h00; pcPlus2_EX = 8'h00; prediction_EX = 1'b0;
  endtask

  initial begin
    //          pcF  br b26 z  k  pcEX pcB  pcP2 pEX | pred tgt  mis red  mc  bc
    vecs[0]  = mk(8'h14, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 0);
    vecs[1]  = mk(8'h14, 1, 0, 1, 0, 8'h14, 8'h30, 8'h16, 0, 0, 8'h00, 1, 8'h30, 0, 0);
    vecs[2]  = mk(8'h14, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 1, 8'h30, 0, 8'h00, 1, 1);
    vecs[3]  = mk(8'h14, 1, 1, 1, 0, 8'h14, 8'h30, 8'h16, 1, 1, 8'h30, 1, 8'h16, 1, 1);
    vecs[4]  = mk(8'h14, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 0, 8'h00, 2, 2);
    vecs[5]  = mk(8'h14, 1, 0, 1, 0, 8'h14, 8'h30, 8'h16, 0, 0, 8'h00, 1, 8'h30, 2, 2);
    vecs[6]  = mk(8'h14, 1, 0, 1, 0, 8'h14, 8'h30, 8'h16, 1, 1, 8'h30, 0, 8'h00, 3, 3);
    vecs[7]  = mk(8'h14, 1, 0, 1, 0, 8'h14, 8'h30, 8'h16, 1, 1, 8'h30, 0, 8'h00, 3, 4);
    vecs[8]  = mk(8'h14, 1, 0, 0, 0, 8'h14, 8'h30, 8'h16, 1, 1, 8'h30, 1, 8'h16, 3, 5);
    vecs[9]  = mk(8'h14, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 1, 8'h30, 0, 8'h00, 4, 6);
    vecs[10] = mk(8'h14, 1, 0, 0, 1, 8'h14, 8'h30, 8'h16, 1, 1, 8'h30, 0, 8'h00, 4, 6);
    vecs[11] = mk(8'h14, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 1, 8'h30, 0, 8'h00, 4, 6);
    vecs[12] = mk(8'h14, 0, 0, 1, 0, 8'h14, 8'h30, 8'h16, 1, 1, 8'h30, 0, 8'h00, 4, 6);
    vecs[13] = mk(8'h24, 1, 0, 1, 0, 8'h24, 8'h50, 8'h26, 0, 0, 8'h00, 1, 8'h50, 4, 6);
    vecs[14] = mk(8'h14, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 0, 8'h00, 5, 7);
    vecs[15] = mk(8'h24, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 1, 8'h50, 0, 8'h00, 5, 7);
    vecs[16] = mk(8'h37, 1, 1, 0, 0, 8'h37, 8'h40, 8'h39, 0, 0, 8'h00, 1, 8'h40, 5, 7);
    vecs[17] = mk(8'h37, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 1, 8'h40, 0, 8'h00, 6, 8);
    vecs[18] = mk(8'h5A, 1, 0, 0, 0, 8'h5A, 8'h60, 8'h5C, 0, 0, 8'h00, 0, 8'h00, 6, 8);
    vecs[19] = mk(8'h5A, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 0, 8'h00, 6, 9);

    drive_idle(8'h14);
    reset = 1'b0;
    #1;
    check("reset_pred", {15'd0, predictionF}, 16'd0);
    check("reset_tgt", {8'd0, predTargetF}, 16'd0);
    check("reset_mis", {15'd0, mispredict_EX}, 16'd0);
    check("reset_redir", {8'd0, redirectPC_EX}, 16'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      pcF = vecs[i].pcf; Branch_EX = vecs[i].br; bit26_EX = vecs[i].b26;
      zero_EX = vecs[i].zero; kill_EX = vecs[i].kill; pc_EX = vecs[i].pcex;
      pcBranch_EX = vecs[i].pcb; pcPlus2_EX = vecs[i].pcp2; prediction_EX = vecs[i].pex;
      #2;
      check($sformatf("v%0d_pred", i), {15'd0, predictionF}, {15'd0, vecs[i].epred});
      check($sformatf("v%0d_tgt", i), {8'd0, predTargetF}, {8'd0, vecs[i].etgt});
      check($sformatf("v%0d_mis", i), {15'd0, mispredict_EX}, {15'd0, vecs[i].emis});
      check($sformatf("v%0d_redir", i), {8'd0, redirectPC_EX}, {8'd0, vecs[i].ered});
      check($sformatf("v%0d_mcnt", i), mispredCount, vecs[i].emc);
      check($sformatf("v%0d_bcnt", i), branchCount, vecs[i].ebc);
    end

    // Asynchronous reset mid-run clears table and statistics without a clock edge.
    @(negedge clk);
    drive_idle(8'h24);
    #2;
    check("pre_reset_pred", {15'd0, predictionF}, 16'd1);
    reset = 1'b0;
    #1;
    check("async_reset_pred", {15'd0, predictionF}, 16'd0);
    check("async_reset_mcnt", mispredCount, 16'd0);
    check("async_reset_bcnt", branchCount, 16'd0);

    // Reset held across an edge where an update is presented: no entry written.
    Branch_EX = 1'b1; zero_EX = 1'b1; pc_EX = 8'h14; pcBranch_EX = 8'h30;
    pcPlus2_EX = 8'h16; prediction_EX = 1'b0;
    @(posedge clk);
    @(negedge clk);
    drive_idle(8'h14);
    reset = 1'b1;
    #2;
    check("rst_upd_pred", {15'd0, predictionF}, 16'd0);
    check("rst_upd_bcnt", branchCount, 16'd0);
    // A single taken resolve on a fresh table predicts taken next cycle.
    Branch_EX = 1'b1; zero_EX = 1'b1; pc_EX = 8'h14; pcBranch_EX = 8'h30;
    pcPlus2_EX = 8'h16;
    @(negedge clk);
    drive_idle(8'h14);
    #2;
    check("post_rst_pred", {15'd0, predictionF}, 16'd1);
    check("post_rst_tgt", {8'd0, predTargetF}, 16'h0030);
    check("post_rst_bcnt", branchCount, 16'd1);
    check("post_rst_mcnt", mispredCount, 16'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, got running expected done");
    $fatal(1);
  end

endmodule
